boot_load_ctrl: RTL

BOOT_LOAD_CTRL -- requirements
Module: boot_load_ctrl

---
 rtl/boot_pkg.sv | 18 +
 rtl/boot_timer.sv | 36 +++
 rtl/boot_load_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - boot loader states and frame constants; S_CHK exists only with BOOT_CHECKSUM_EN
package boot_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LEN_BYTES  = 2;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
`ifdef BOOT_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERROR
  } boot_state_t;

endpackage

// File: rtl/boot_timer.sv
// rtl/boot_timer.sv - inter-byte idle timer; expired_o flags the TIMEOUT_CYC-th idle cycle
module boot_timer #(
  parameter int unsigned TIMEOUT_CYC = 4_000_000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A clear in the terminal cycle masks expiry, so an arriving byte always wins
  assign expired_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (!expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/boot_load_ctrl.sv
// rtl/boot_load_ctrl.sv - UART boot loader writing a length-prefixed frame into imem; BOOT_CHECKSUM_EN adds a trailing XOR byte
module boot_load_ctrl
  import boot_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int unsigned TIMEOUT_CYC = 4_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int LW = ADDR_W + 1;

  boot_state_t            state_q;
  logic [7:0]             len_lo_q;
  logic [LW-1:0]          len_q;
  logic [LW-1:0]          words_q;
  logic [1:0]             idx_q;
  logic [23:0]            part_q;
  logic                   we_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [31:0]            wdata_q;
  logic                   hold_q;
  logic                   done_q;
  logic                   err_q;
  logic [8*LEN_BYTES-1:0] len_d;
  logic                   len_too_big;
  logic                   tmr_en;
  logic                   expired;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]             csum_q;
`endif

  assign len_d       = {rx_data, len_lo_q};
  assign len_too_big = 32'(len_d) > (32'd1 << ADDR_W);

  always_comb begin
    tmr_en = (state_q == S_LEN_HI) || (state_q == S_DATA);
`ifdef BOOT_CHECKSUM_EN
    if (state_q == S_CHK) tmr_en = 1'b1;
`endif
  end

  boot_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk_i    (clk),
    .reset_i  (reset),
    .clr_i    (rx_valid),
    .en_i     (tmr_en),
    .expired_o(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_LEN_LO;
      len_lo_q <= '0;
      len_q    <= '0;
      words_q  <= '0;
      idx_q    <= '0;
      part_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_LEN_LO: begin
          if (rx_valid) begin
            len_lo_q <= rx_data;
            state_q  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (rx_valid) begin
            if (len_d == '0) begin
`ifdef BOOT_CHECKSUM_EN
              state_q <= S_CHK;
`else
              state_q <= S_DONE;
              hold_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end else if (len_too_big) begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
            end else begin
              len_q   <= LW'(len_d);
              state_q <= S_DATA;
            end
          end else if (expired) begin
            state_q <= S_ERROR;
            err_q   <= 1'b1;
          end
        end
        S_DATA: begin
          // words_q == len_q only in the write cycle of the final word
          if (words_q == len_q) begin
`ifdef BOOT_CHECKSUM_EN
            if (rx_valid) begin
              if (rx_data == csum_q) begin
                state_q <= S_DONE;
                hold_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_ERROR;
                err_q   <= 1'b1;
              end
            end else if (expired) begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_CHK;
            end
`else
            state_q <= S_DONE;
            hold_q  <= 1'b0;
            done_q  <= 1'b1;
`endif
          end else if (rx_valid) begin
            idx_q <= idx_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
            csum_q <= csum_q ^ rx_data;
`endif
            if (idx_q == 2'(WORD_BYTES - 1)) begin
              we_q    <= 1'b1;
              addr_q  <= words_q[ADDR_W-1:0];
              wdata_q <= {rx_data, part_q};
              words_q <= words_q + 1'b1;
            end else begin
              part_q <= {rx_data, part_q[23:8]};
            end
          end else if (expired) begin
            state_q <= S_ERROR;
            err_q   <= 1'b1;
          end
        end
`ifdef BOOT_CHECKSUM_EN
        S_CHK: begin
          if (rx_valid) begin
            if (rx_data == csum_q) begin
              state_q <= S_DONE;
              hold_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
            end
          end else if (expired) begin
            state_q <= S_ERROR;
            err_q   <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_hold     = hold_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = words_q;

endmodule
